// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory bus arbiter.
// Included by the arbiter top and its starvation counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int MAX_WAIT_DEFAULT = 4;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Saturating DMA starvation counter; raises force-grant once the DMA port
// has been denied MAX_WAIT consecutive cycles.
module mem_arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  localparam int CW = $clog2(MAX_WAIT + 1)
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_dmaReq,
  input  logic i_dmaGnt,
  output logic o_forceGrant
);

  logic [CW-1:0] r_waitCnt;

  // A dropped request or a grant restarts the count; otherwise count up and hold at the limit.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_waitCnt <= '0;
    end else if (!i_dmaReq || i_dmaGnt) begin
      r_waitCnt <= '0;
    end else if (r_waitCnt != CW'(MAX_WAIT)) begin
      r_waitCnt <= r_waitCnt + CW'(1);
    end
  end

  assign o_forceGrant = (r_waitCnt == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU-priority arbiter sharing a single-port memory with a DMA port, with
// bounded DMA wait and registered one-cycle read return.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic [7:0] dma_rdata,
  output logic       dma_rvalid,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output owner_t     owner
);

  logic     w_forceGrant;
  logic     w_cpuGnt;
  logic     w_dmaGnt;
  mem_req_t w_cpuReq;
  mem_req_t w_dmaReq;
  mem_req_t w_memReq;
  owner_t   w_nextOwner;
  owner_t   r_owner;
  logic     r_readPend;
  logic [7:0] r_cpuRdata;
  logic [7:0] r_dmaRdata;

  mem_arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_waitCounter (
    .i_clk        (clk),
    .i_rstN       (reset),
    .i_dmaReq     (dma_req),
    .i_dmaGnt     (w_dmaGnt),
    .o_forceGrant (w_forceGrant)
  );

  // CPU wins contention unless the DMA port has waited its full budget.
  assign w_cpuGnt = reset & cpu_req & ~(dma_req & w_forceGrant);
  assign w_dmaGnt = reset & dma_req & (~cpu_req | w_forceGrant);

  assign w_cpuReq = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign w_dmaReq = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

  always_comb begin
    w_memReq    = '0;
    w_nextOwner = OWN_NONE;
    if (w_cpuGnt) begin
      w_memReq    = w_cpuReq;
      w_nextOwner = OWN_CPU;
    end else if (w_dmaGnt) begin
      w_memReq    = w_dmaReq;
      w_nextOwner = OWN_DMA;
    end
  end

  assign mem_addr  = w_memReq.addr;
  assign mem_wdata = w_memReq.wdata;
  assign mem_we    = w_memReq.we;

  // Read data is captured per port; owner plus the pending flag steer the rvalid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= OWN_NONE;
      r_readPend <= 1'b0;
      r_cpuRdata <= '0;
      r_dmaRdata <= '0;
    end else begin
      r_owner    <= w_nextOwner;
      r_readPend <= (w_cpuGnt & ~cpu_we) | (w_dmaGnt & ~dma_we);
      if (w_cpuGnt && !cpu_we) r_cpuRdata <= mem_rdata;
      if (w_dmaGnt && !dma_we) r_dmaRdata <= mem_rdata;
    end
  end

  assign cpu_gnt    = w_cpuGnt;
  assign dma_gnt    = w_dmaGnt;
  assign cpu_rdata  = r_cpuRdata;
  assign dma_rdata  = r_dmaRdata;
  assign cpu_rvalid = r_readPend & (r_owner == OWN_CPU);
  assign dma_rvalid = r_readPend & (r_owner == OWN_DMA);
  assign owner      = r_owner;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the single-port 8-bit `Memory` between the `CPU` and a DMA/program-loader port, one access per clock. It sits between the requesters and `Memory` in the top-level machine, replacing the direct CPU-to-memory wiring. The CPU has priority, and a starvation counter guarantees the DMA port a slot within a bounded number of cycles. Read data is registered and returned one cycle after the grant.

## Interface
- `MAX_WAIT`, default 4: cycles a requesting DMA port may be denied before it is forced a grant. Legal range is 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU requests an access this cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  8  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_gnt`  out  1  CPU access is presented to memory this cycle.
- `cpu_rdata`  out  8  registered read data.
- `cpu_rvalid`  out  1  one-cycle pulse: `cpu_rdata` is valid.
- `dma_req`, `dma_we`, `dma_addr[7:0]`, `dma_wdata[7:0]`  in: same meaning for the DMA port.
- `dma_gnt`, `dma_rdata[7:0]`, `dma_rvalid`  out: same meaning for the DMA port.
- `mem_addr`  out  8  address to `Memory`.
- `mem_wdata`  out  8  write data to `Memory`.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  8  memory read data, combinational from `mem_addr`.

## Operation
**Grant decision.** The grant is combinational from the current-cycle requests and `wait_cnt`:
- Only `cpu_req` asserted: CPU is granted.
- Only `dma_req` asserted: DMA is granted.
- Both asserted and `wait_cnt < MAX_WAIT`: CPU is granted.
- Both asserted and `wait_cnt == MAX_WAIT`: DMA is granted.
- Neither asserted: no grant.

**Mux.**
- The granted requester drives `mem_addr`/`mem_wdata`.
- `mem_we = gnt & we` of the granted requester.
- With no grant, `mem_addr`, `mem_wdata` and `mem_we` are driven to 0.

**Starvation counter `wait_cnt`** (width `$clog2(MAX_WAIT+1)`):
- Increments on each edge where `dma_req & !dma_gnt`.
- Clears to 0 on an edge where `dma_gnt` is high or `dma_req` is low.
- Saturates at `MAX_WAIT`; it never wraps.

**Read return.**
- On an edge where a read is granted, `mem_rdata` is captured into that port's `*_rdata`, and its `*_rvalid` is high for exactly the next cycle.
- `*_rdata` holds its value until the next read for that port.
- Granted writes produce no `rvalid`.

**Owner register.** `owner` is one of `OWN_NONE`, `OWN_CPU`, `OWN_DMA` and records the requester granted on the last edge. It routes read return and is exposed for debug.

**Requester rule.** A requester holds `req`, `we`, `addr` and `wdata` stable until it samples its `gnt` high at an edge. It may drop `req` before being granted; in that case nothing is issued.

**Reset.**
- `reset` low immediately forces `wait_cnt=0`, `owner=OWN_NONE`, `*_rvalid=0` and `*_rdata=0`.
- Grants and `mem_*` outputs are forced to 0 while reset is low.
- A read in flight when reset asserts is dropped; no `rvalid` follows reset release.

## Timing
- Grant latency is 0 cycles: `gnt` is valid in the same cycle as `req`, and the access commits at that cycle's rising edge.
- Read latency is 1 cycle: `rvalid` and `rdata` are valid in the cycle after the grant.
- Throughput is one access per cycle in total, with back-to-back grants to the same port allowed.
- DMA worst-case wait under continuous CPU traffic is `MAX_WAIT` denied cycles; the grant comes in cycle `MAX_WAIT+1`.
- Both ports can receive read data on consecutive cycles, but never in the same cycle: at most one `rvalid` is high per cycle.
- The path from `req`/`addr` through the mux to memory and from `mem_rdata` to the capture register is combinational in one cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - `owner_t` enum (`OWN_NONE`, `OWN_CPU`, `OWN_DMA`).
  - `MAX_WAIT_DEFAULT = 4`.
  - A `mem_req_t` packed struct {`we`, `addr[7:0]`, `wdata[7:0]`} used by the mux.
- One sub-module, `mem_arb_wait_counter`, implements the saturating starvation counter with a `force_grant` output (`wait_cnt == MAX_WAIT`).
- The top level holds the grant logic, the mux, the owner register and the read-return registers.

## Test plan
1. **Reset value check.** Drive `reset` low mid-simulation. All outputs must be 0 and `owner=OWN_NONE`. After release with no requests, all outputs stay 0.
2. **CPU-only read.** Memory[0x10]=0x5A; CPU read of 0x10. Required: `cpu_gnt` high in the same cycle, `mem_addr=0x10`, `mem_we=0`; next cycle `cpu_rvalid=1` and `cpu_rdata=0x5A`; `dma_rvalid` stays 0.
3. **DMA-only write, then CPU read.** DMA write 0x20←0xC3. Required: `mem_we=1` for one cycle. A following CPU read of 0x20 returns 0xC3.
4. **Continuous contention, `MAX_WAIT=4`.** Both ports request every cycle. Grants must repeat CPU,CPU,CPU,CPU,DMA, with `dma_gnt` first high in cycle 5.
5. **DMA withdraws.** DMA requests for 3 denied cycles, drops `req` for 1 cycle, then re-raises. `wait_cnt` must clear, and DMA must wait 4 more denied cycles before its grant.
6. **Reset during read.** CPU read granted, then `reset` low before the next edge. Required: `cpu_rvalid` is never asserted, both before and after reset release.
